// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ requesters of 9-bit words.
// Define UART_TX_ARB_WATCHDOG_EN to enable the frame watchdog that drives timeout_err.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = 65535
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [9*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 tx_send,
  output logic [8:0]           tx_data,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [ID_W-1:0]      active_id,
  output logic                 frame_done,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] winner;
  logic            found;

`ifdef UART_TX_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        wd_hit;
  assign wd_hit = (wd_cnt == 16'(TIMEOUT - 1));
`else
  assign timeout_err = 1'b0;
`endif

  // First requester at or above ptr+1, wrapping; the last-served one is checked last.
  always_comb begin
    int unsigned idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= ID_W'(NUM_REQ - 1);
      gnt        <= '0;
      tx_send    <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
      active_id  <= '0;
      frame_done <= 1'b0;
`ifdef UART_TX_ARB_WATCHDOG_EN
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      gnt        <= '0;
      tx_send    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          // Winner, word and pointer are all taken on the edge that raises gnt.
          if (found && tx_ready) begin
            gnt       <= NUM_REQ'(1) << winner;
            tx_data   <= req_data[9*winner +: 9];
            active_id <= winner;
            ptr       <= winner;
            busy      <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          tx_send <= 1'b1;
          state   <= ISSUE;
        end
        ISSUE: begin
`ifdef UART_TX_ARB_WATCHDOG_EN
          wd_cnt <= '0;
`endif
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!tx_ready) begin
`ifdef UART_TX_ARB_WATCHDOG_EN
            wd_cnt <= '0;
`endif
            state <= WAIT_DONE;
          end
`ifdef UART_TX_ARB_WATCHDOG_EN
          else if (wd_hit) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= GAP;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end
        WAIT_DONE: begin
          if (tx_ready) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= GAP;
          end
`ifdef UART_TX_ARB_WATCHDOG_EN
          else if (wd_hit) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= GAP;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end
        // uart_tx shows ready during its last stop tick but cannot accept send yet.
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a behavioural transmitter
// and per-requester word queues.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset_n = 1'b1;
  logic [N-1:0]   req = '0;
  logic [9*N-1:0] req_data = '0;
  logic           tx_ready = 1'b1;
  logic [N-1:0]   gnt;
  logic           tx_send;
  logic [8:0]     tx_data;
  logic           busy;
  logic [1:0]     active_id;
  logic           frame_done;
  logic           timeout_err;

  always #5 clock = ~clock;

  uart_tx_arbiter #(.NUM_REQ(N), .ID_W(2), .TIMEOUT(100)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data),
    .gnt(gnt), .tx_send(tx_send), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .active_id(active_id), .frame_done(frame_done),
    .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [8:0] pend[N][$];
  logic [8:0] exp_words[$];
  logic [8:0] got_words[$];
  int         gnt_log[$];
  int         sends = 0, dones = 0, cyc = 0;
  int         last_gnt_cyc = -100, last_done_cyc = -100;
  int         send_cyc = 0, err_cyc = -1;
  bit         in_frame = 0;
  logic [8:0] frame_data = '0;
  int         accept_delay = 0, frame_len = 10;
  bit         stuck = 0;

  task automatic post(input int i, input logic [8:0] w);
    pend[i].push_back(w);
    if (pend[i].size() == 1) begin
      req_data[9*i +: 9] = w;
      req[i] = 1'b1;
    end
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    exp_words.delete();
    got_words.delete();
    sends = 0;
    dones = 0;
    for (int i = 0; i < N; i++) pend[i].delete();
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clock);
    clear_logs();
    reset_n = 1'b1;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int k;
    k = 0;
    while (k < budget && !(req == '0 && !busy && tx_ready)) begin
      @(negedge clock);
      k++;
    end
    check({tag, "_budget"}, 32'(k < budget), 1);
    repeat (3) @(negedge clock);
  endtask

  // Behavioural transmitter: drops ready on accepting send, raises it when the frame ends.
  initial forever begin
    @(posedge clock);
    #1;
    if (tx_send) begin
      for (int k = 0; k < accept_delay; k++) begin
        @(posedge clock);
        #1;
      end
      tx_ready = 1'b0;
      got_words.push_back(tx_data);
      if (stuck) begin
        while (stuck) @(posedge clock);
      end else begin
        repeat (frame_len) @(posedge clock);
      end
      #1 tx_ready = 1'b1;
    end
  end

  // Requesters plus protocol monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clock);
    cyc++;
    if (!reset_n) begin
      in_frame = 0;
      continue;
    end
    if (gnt != '0) begin
      check("gnt_onehot", 32'($onehot(gnt)), 1);
      check("gnt_has_req", 32'(gnt & ~req), 0);
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          check("active_id", 32'(active_id), i);
          gnt_log.push_back(i);
          if (pend[i].size() > 0) exp_words.push_back(pend[i].pop_front());
          if (pend[i].size() > 0) req_data[9*i +: 9] = pend[i][0];
          else req[i] = 1'b0;
        end
      end
      last_gnt_cyc = cyc;
    end
    if (tx_send) begin
      check("send_after_gnt", 32'(cyc - last_gnt_cyc), 1);
      check("single_send", 32'(in_frame), 0);
      check("issue_spacing", 32'((cyc - last_done_cyc) >= 2), 1);
      in_frame = 1;
      frame_data = tx_data;
      sends++;
      send_cyc = cyc;
    end
    if (frame_done) begin
      check("data_stable", 32'(tx_data), 32'(frame_data));
      check("done_in_frame", 32'(in_frame), 1);
      in_frame = 0;
      dones++;
      last_done_cyc = cyc;
    end
    if (timeout_err && err_cyc < 0) begin
      err_cyc = cyc;
      in_frame = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stalled expected finish");
    $fatal(1, "bench stalled");
  end

  initial begin
    // Asynchronous reset before any clock edge.
    #2 reset_n = 1'b0;
    #1 check("rst_outputs", 32'({gnt, tx_send, tx_data, busy, active_id, frame_done, timeout_err}), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Single request.
    post(2, 9'h1A5);
    wait_quiet("t1", 200);
    check("t1_gnt_count", 32'(gnt_log.size()), 1);
    if (gnt_log.size() > 0) check("t1_gnt_id", 32'(gnt_log[0]), 2);
    check("t1_word_count", 32'(got_words.size()), 1);
    if (got_words.size() > 0) check("t1_word", 32'(got_words[0]), 32'h1A5);
    check("t1_dones", 32'(dones), 1);
    check("t1_busy", 32'(busy), 0);

    // All four requesting from reset: rotation starts at 0.
    apply_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) post(i, 9'(i * 16 + r + 3));
    wait_quiet("t2", 1000);
    check("t2_gnt_count", 32'(gnt_log.size()), 8);
    for (int k = 0; k < 8; k++)
      if (k < gnt_log.size()) check("t2_order", 32'(gnt_log[k]), 32'(k % N));
    check("t2_words", 32'(got_words.size()), 8);
    for (int k = 0; k < 8; k++)
      if (k < got_words.size() && k < exp_words.size())
        check("t2_word", 32'(got_words[k]), 32'(exp_words[k]));
    check("t2_sends_eq_dones", 32'(sends), 32'(dones));

    // Pointer at 1, requesters 3 and 1 rise together: 3 wins, then 1.
    post(1, 9'h011);
    wait_quiet("t3a", 200);
    clear_logs();
    post(3, 9'h033);
    post(1, 9'h111);
    wait_quiet("t3b", 400);
    check("t3_gnt_count", 32'(gnt_log.size()), 2);
    if (gnt_log.size() > 1) begin
      check("t3_first", 32'(gnt_log[0]), 3);
      check("t3_second", 32'(gnt_log[1]), 1);
    end

    // Back-to-back frames with slow acceptance.
    clear_logs();
    accept_delay = 2;
    post(0, 9'h000);
    post(0, 9'h1FF);
    post(0, 9'h0AA);
    wait_quiet("t4", 600);
    accept_delay = 0;
    check("t4_words", 32'(got_words.size()), 3);
    if (got_words.size() == 3) begin
      check("t4_w0", 32'(got_words[0]), 32'h000);
      check("t4_w1", 32'(got_words[1]), 32'h1FF);
      check("t4_w2", 32'(got_words[2]), 32'h0AA);
    end
    check("t4_dones", 32'(dones), 3);

    // Reset while waiting for the frame to finish, then re-serve the requester.
    clear_logs();
    post(2, 9'h155);
    begin
      int k;
      k = 0;
      while (k < 50 && !(busy && !tx_ready)) begin
        @(negedge clock);
        k++;
      end
      check("t5_reach_wait", 32'(k < 50), 1);
    end
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b0;
    req = '0;
    #1 check("t5_rst_outputs", 32'({gnt, tx_send, tx_data, busy, active_id, frame_done, timeout_err}), 0);
    repeat (2) @(negedge clock);
    clear_logs();
    reset_n = 1'b1;
    post(2, 9'h155);
    wait_quiet("t5", 300);
    check("t5_gnt_count", 32'(gnt_log.size()), 1);
    if (gnt_log.size() > 0) check("t5_gnt_id", 32'(gnt_log[0]), 2);
    check("t5_words", 32'(got_words.size()), 1);
    if (got_words.size() > 0) check("t5_word", 32'(got_words[0]), 32'h155);
    check("t5_dones", 32'(dones), 1);

`ifdef UART_TX_ARB_WATCHDOG_EN
    // Transmitter never finishes: watchdog fires, next requester still served.
    clear_logs();
    stuck = 1;
    post(1, 9'h0F0);
    begin
      int k;
      k = 0;
      while (k < 400 && err_cyc < 0) begin
        @(negedge clock);
        k++;
      end
      check("t6_wd_fired", 32'(k < 400), 1);
    end
    check("t6_wd_latency", 32'(err_cyc - send_cyc), 102);
    check("t6_timeout_err", 32'(timeout_err), 1);
    check("t6_no_done", 32'(dones), 0);
    check("t6_busy", 32'(busy), 0);
    stuck = 0;
    repeat (3) @(negedge clock);
    post(3, 9'h033);
    wait_quiet("t6", 300);
    check("t6_dones", 32'(dones), 1);
    if (gnt_log.size() > 0) check("t6_last_gnt", 32'(gnt_log[gnt_log.size()-1]), 3);
    check("t6_sticky", 32'(timeout_err), 1);
`else
    check("no_watchdog", 32'(timeout_err), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
